// File: rtl/axis_pattern_src_pkg.sv
// Shared definitions for the AXI4-Stream pattern source: pattern modes, FSM
// encodings, ctrl/status register bit positions and the LFSR step function.
package axis_pattern_src_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Register bit map, mirrored by the PS software header.
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_MODE_LSB  = 2;
    localparam int CTRL_MODE_MSB  = 3;

    localparam int STAT_BUSY_BIT  = 31;
    localparam int STAT_DONE_BIT  = 30;
    localparam int STAT_ERR_BIT   = 29;
    localparam int STAT_ABORT_BIT = 28;
    localparam int STAT_FCNT_W    = 16;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/axis_pattern_src_lfsr32.sv
// 32-bit Galois LFSR: loads the seed on demand and steps once per advance.
module axis_pattern_src_lfsr32
    import axis_pattern_src_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/axis_pattern_src.sv
// AXI4-Stream test-pattern source: one frame of LEN words per start edge,
// driven by PS control registers and reporting status/counters back.
module axis_pattern_src
    import axis_pattern_src_pkg::*;
#(
    parameter int          LEN_W     = 24,
    parameter logic [31:0] LFSR_SEED = 32'h1ACE_B00C,
    parameter logic [31:0] CONST_VAL = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ctrl,
    input  logic [31:0] length,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] status,
    output logic [31:0] beat_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e            state_q, state_d;
    logic              ctrl_q, ctrl_d;
    logic              armed_q, armed_d;
    mode_e             mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              abort_q, abort_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic              start;
    logic              abort_req;
    logic              xfer;
    logic [LEN_W-1:0]  len_in;
    logic [LEN_W-1:0]  idx_nxt;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic [31:0]       lfsr_word;
    logic [23:0]       idx_lo;
    logic [31:0]       word;
    logic              unused_bits;

    assign unused_bits = ^{ctrl[31:CTRL_MODE_MSB+1], length[31:LEN_W]};

    // armed_q blocks a start that was already high when reset released.
    assign start     = ctrl[CTRL_START_BIT] & ~ctrl_q & armed_q;
    assign abort_req = ctrl[CTRL_ABORT_BIT];
    assign xfer      = tvalid_q & m_axis_tready;
    assign len_in    = length[LEN_W-1:0];
    assign idx_nxt   = idx_q + LEN_ONE;

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl[CTRL_START_BIT];
        armed_d     = armed_q | ~ctrl[CTRL_START_BIT];
        mode_d      = mode_q;
        len_d       = len_q;
        idx_d       = idx_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        abort_d     = abort_q;
        done_d      = done_q;
        err_d       = err_q;
        aborted_d   = aborted_q;
        frame_cnt_d = frame_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    if (len_in == '0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = S_RUN;
                        tvalid_d    = 1'b1;
                        tlast_d     = (len_in == LEN_ONE);
                        mode_d      = mode_e'(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                        len_d       = len_in;
                        idx_d       = '0;
                        abort_d     = 1'b0;
                        beat_cnt_d  = '0;
                        stall_cnt_d = '0;
                        lfsr_load   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    lfsr_adv   = 1'b1;
                    if (tlast_q) begin
                        state_d     = S_IDLE;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        done_d      = 1'b1;
                        aborted_d   = abort_q;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        // An abort seen on a transferring beat terminates the next one.
                        idx_d   = idx_nxt;
                        tlast_d = (idx_nxt == len_q - LEN_ONE) | abort_req;
                        abort_d = abort_q | abort_req;
                    end
                end else begin
                    if (tvalid_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end
                    // Held beat has not handshaken yet, so only tlast may change.
                    tlast_d = tlast_q | abort_req;
                    abort_d = abort_q | abort_req;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ctrl_q      <= 1'b0;
            armed_q     <= 1'b0;
            mode_q      <= MODE_CNT;
            len_q       <= '0;
            idx_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
            frame_cnt_q <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            armed_q     <= armed_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
            err_q       <= err_d;
            aborted_q   <= aborted_d;
            frame_cnt_q <= frame_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    axis_pattern_src_lfsr32 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .advance (lfsr_adv),
        .q       (lfsr_word)
    );

    // Output word is a pure function of registered state, so it holds during stalls.
    assign idx_lo = 24'(idx_q);

    always_comb begin
        word = '0;
        case (mode_q)
            MODE_CNT:   word = {frame_cnt_q[7:0], idx_lo};
            MODE_LFSR:  word = lfsr_word;
            MODE_CONST: word = CONST_VAL;
            MODE_WALK:  word = 32'd1 << idx_q[4:0];
            default:    word = '0;
        endcase
    end

    assign m_axis_tdata  = tvalid_q ? word : '0;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    always_comb begin
        status                          = '0;
        status[STAT_BUSY_BIT]           = (state_q == S_RUN);
        status[STAT_DONE_BIT]           = done_q;
        status[STAT_ERR_BIT]            = err_q;
        status[STAT_ABORT_BIT]          = aborted_q;
        status[STAT_FCNT_W-1:0]         = frame_cnt_q;
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_axis_pattern_src.sv
// Bench for axis_pattern_src: directed frames with hand-computed beats pushed
// into an expected queue and popped by an independent stream monitor.
module tb_axis_pattern_src;

    logic        clk;
    logic        reset;
    logic [31:0] ctrl;
    logic [31:0] length;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] status;
    logic [31:0] beat_cnt;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];

    axis_pattern_src dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl          (ctrl),
        .length        (length),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .status        (status),
        .beat_cnt      (beat_cnt),
        .stall_cnt     (stall_cnt)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic last, input logic [31:0] data);
        exp_q.push_back({last, data});
    endtask

    task automatic start_frame(input logic [1:0] mode, input logic [31:0] len);
        ctrl   = {28'b0, mode, 1'b0, 1'b1};
        length = len;
        tick(1);
        ctrl[0] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((m_axis_tvalid || status[31]) && n < budget) begin
            tick(1);
            n++;
        end
        check("done_in_budget", 64'(n < budget), 64'd1);
    endtask

    // Monitor / scoreboard
    logic        hold_v = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check("hold_data", 64'(m_axis_tdata), 64'(hold_data));
                if (hold_last) check("hold_last", 64'(m_axis_tlast), 64'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", {m_axis_tlast, m_axis_tdata});
                end else begin
                    check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
                end
            end
            hold_v    = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            hold_last = m_axis_tlast;
        end
    end

    // Directed stimulus
    initial begin
        reset         = 1'b1;
        ctrl          = 32'h1;
        length        = 32'd4;
        m_axis_tready = 1'b1;
        tick(3);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_beat", 64'(beat_cnt), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);

        // Start held high across reset release must not fire.
        reset = 1'b0;
        tick(3);
        check("no_start_at_exit_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("no_start_at_exit_status", 64'(status), 64'd0);
        ctrl = 32'h0;
        tick(1);

        // Counter mode, len 4, back-to-back
        for (int i = 0; i < 4; i++) push(i == 3, 32'(i));
        start_frame(2'd0, 32'd4);
        tick(4);
        check("t1_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t1_status", 64'(status), 64'h4000_0001);
        check("t1_beat", 64'(beat_cnt), 64'd4);
        check("t1_stall", 64'(stall_cnt), 64'd0);

        // LFSR mode, len 3, two stall cycles on beat 1
        push(1'b0, 32'h1ACE_B00C);
        push(1'b0, 32'h0D67_5806);
        push(1'b1, 32'h06B3_AC03);
        start_frame(2'd1, 32'd3);
        tick(1);
        m_axis_tready = 1'b0;
        tick(2);
        m_axis_tready = 1'b1;
        tick(2);
        check("t2_status", 64'(status), 64'h4000_0002);
        check("t2_beat", 64'(beat_cnt), 64'd3);
        check("t2_stall", 64'(stall_cnt), 64'd2);

        // Zero length, then single beat
        start_frame(2'd2, 32'd0);
        check("t3_err_status", 64'(status), 64'h2000_0002);
        tick(2);
        check("t3_no_tvalid", 64'(m_axis_tvalid), 64'd0);
        push(1'b1, 32'hDEAD_BEEF);
        start_frame(2'd2, 32'd1);
        tick(1);
        check("t3_len1_status", 64'(status), 64'h4000_0003);
        check("t3_len1_beat", 64'(beat_cnt), 64'd1);

        // Abort while beat 5 of 100 is presented, tready high
        for (int i = 0; i < 7; i++) push(i == 6, {8'h03, 24'(i)});
        start_frame(2'd0, 32'd100);
        tick(5);
        ctrl = 32'h2;
        tick(2);
        ctrl = 32'h0;
        check("t4_status", 64'(status), 64'h5000_0004);
        check("t4_beat", 64'(beat_cnt), 64'd7);
        check("t4_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Abort on a held beat: tlast rises, data unchanged
        m_axis_tready = 1'b0;
        push(1'b1, 32'hDEAD_BEEF);
        start_frame(2'd2, 32'd10);
        ctrl = 32'hA;
        tick(1);
        m_axis_tready = 1'b1;
        ctrl = 32'h0;
        tick(1);
        check("t4b_status", 64'(status), 64'h5000_0005);
        check("t4b_beat", 64'(beat_cnt), 64'd1);
        check("t4b_stall", 64'(stall_cnt), 64'd1);

        // Start re-pulse and length rewrite mid-frame are ignored
        for (int i = 0; i < 5; i++) push(i == 4, {8'h05, 24'(i)});
        start_frame(2'd0, 32'd5);
        tick(2);
        ctrl   = 32'h1;
        length = 32'd2;
        tick(1);
        ctrl   = 32'h0;
        length = 32'd50;
        tick(2);
        check("t5_status", 64'(status), 64'h4000_0006);
        check("t5_beat", 64'(beat_cnt), 64'd5);
        tick(4);
        check("t5_no_second_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_no_second_status", 64'(status), 64'h4000_0006);

        // Walking one across the 32-bit wrap
        for (int i = 0; i < 34; i++) push(i == 33, 32'd1 << (i % 32));
        start_frame(2'd3, 32'd34);
        wait_done(100);
        check("t7_status", 64'(status), 64'h4000_0007);
        check("t7_beat", 64'(beat_cnt), 64'd34);

        // LFSR len 4 reaches a feedback step
        push(1'b0, 32'h1ACE_B00C);
        push(1'b0, 32'h0D67_5806);
        push(1'b0, 32'h06B3_AC03);
        push(1'b1, 32'h8379_D602);
        start_frame(2'd1, 32'd4);
        wait_done(20);
        check("t8_status", 64'(status), 64'h4000_0008);

        // Reset in the middle of a stalled frame
        m_axis_tready = 1'b0;
        start_frame(2'd1, 32'd8);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_tlast", 64'(m_axis_tlast), 64'd0);
        check("t6_tdata", 64'(m_axis_tdata), 64'd0);
        check("t6_status", 64'(status), 64'd0);
        check("t6_beat", 64'(beat_cnt), 64'd0);
        check("t6_stall", 64'(stall_cnt), 64'd0);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        tick(1);
        push(1'b0, 32'h0000_0000);
        push(1'b1, 32'h0000_0001);
        start_frame(2'd0, 32'd2);
        tick(2);
        check("t6_clean_status", 64'(status), 64'h4000_0001);
        check("t6_clean_beat", 64'(beat_cnt), 64'd2);

        tick(2);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
